sys_bus_decoder: RTL and testbench



---
 rtl/sys_bus_decoder.sv | 177 +++++++++++++++++
 tb/tb_sys_bus_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_decoder.sv
// System bus address decoder.
// Accepts one upstream request at a time, forwards a registered one-hot strobe
// to the addressed region and returns a registered single-cycle ack. Unmapped
// regions and subordinates that stay silent for TMO cycles complete with an
// error, well inside the upstream 32-cycle watchdog.
module sys_bus_decoder #(
  parameter int unsigned    SYS_DW  = 64,
  parameter int unsigned    SYS_AW  = 32,
  parameter int unsigned    SYS_SW  = SYS_DW >> 3,
  parameter int unsigned    SN      = 8,
  parameter int unsigned    DEC_LSB = 20,
  parameter logic [SN-1:0]  REG_EN  = {SN{1'b1}},
  parameter int unsigned    TMO     = 16
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rstn_i,
  input  logic [SYS_AW-1:0]    sys_addr_i,
  input  logic [SYS_DW-1:0]    sys_wdata_i,
  input  logic [SYS_SW-1:0]    sys_sel_i,
  input  logic                 sys_wen_i,
  input  logic                 sys_ren_i,
  output logic [SYS_DW-1:0]    sys_rdata_o,
  output logic                 sys_err_o,
  output logic                 sys_ack_o,
  output logic [SYS_AW-1:0]    sub_addr_o,
  output logic [SYS_DW-1:0]    sub_wdata_o,
  output logic [SYS_SW-1:0]    sub_sel_o,
  output logic [SN-1:0]        sub_wen_o,
  output logic [SN-1:0]        sub_ren_o,
  input  logic [SN*SYS_DW-1:0] sub_rdata_i,
  input  logic [SN-1:0]        sub_err_i,
  input  logic [SN-1:0]        sub_ack_i
);

  // Region field width; a single-region build still carries one (ignored) bit.
  localparam int unsigned RW = (SN > 1) ? $clog2(SN) : 1;
  localparam int unsigned CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StUerr} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       region_q, region_d;
  logic                wr_q, wr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SYS_AW-1:0]   addr_q, addr_d;
  logic [SYS_DW-1:0]   wdata_q, wdata_d;
  logic [SYS_SW-1:0]   sel_q, sel_d;
  logic [SN-1:0]       wen_q, wen_d;
  logic [SN-1:0]       ren_q, ren_d;
  logic [SYS_DW-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ack_q, ack_d;

  logic                req;
  logic [RW-1:0]       region_in;
  logic [SN-1:0]       region_oh;
  logic                sel_ack;
  logic                timeout;

  assign req       = sys_wen_i | sys_ren_i;
  assign region_in = sys_addr_i[DEC_LSB +: RW];
  assign sel_ack   = sub_ack_i[region_q];
  assign timeout   = (cnt_q == CW'(TMO));

  // One-hot decode of the incoming region field.
  always_comb begin
    region_oh = '0;
    region_oh[region_in] = 1'b1;
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      state_q  <= StIdle;
      region_q <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      wen_q    <= '0;
      ren_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
    end
  end

  // Next-state logic; a real ack takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req) state_d = REG_EN[region_in] ? StBusy : StUerr;
      end
      StBusy: begin
        if (sel_ack || timeout) state_d = StIdle;
      end
      StUerr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath/output next values: strobes, ack and err are one-cycle pulses.
  always_comb begin
    region_d = region_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    wen_d    = '0;
    ren_d    = '0;
    err_d    = 1'b0;
    ack_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          region_d = region_in;
          wr_d     = sys_wen_i;
          addr_d   = sys_addr_i;
          wdata_d  = sys_wdata_i;
          sel_d    = sys_sel_i;
          cnt_d    = CW'(1);
          if (REG_EN[region_in]) begin
            // Write wins when both strobes are high.
            if (sys_wen_i) wen_d = region_oh;
            else           ren_d = region_oh;
          end
        end
      end
      StBusy: begin
        if (sel_ack) begin
          ack_d = 1'b1;
          err_d = sub_err_i[region_q];
          if (!wr_q) rdata_d = sub_rdata_i[region_q*SYS_DW +: SYS_DW];
        end else if (timeout) begin
          ack_d = 1'b1;
          err_d = 1'b1;
          if (!wr_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StUerr: begin
        ack_d = 1'b1;
        err_d = 1'b1;
        if (!wr_q) rdata_d = '0;
      end
      default: ;
    endcase
  end

  assign sys_rdata_o = rdata_q;
  assign sys_err_o   = err_q;
  assign sys_ack_o   = ack_q;
  assign sub_addr_o  = addr_q;
  assign sub_wdata_o = wdata_q;
  assign sub_sel_o   = sel_q;
  assign sub_wen_o   = wen_q;
  assign sub_ren_o   = ren_q;

endmodule

// File: tb/tb_sys_bus_decoder.sv
// Directed bench for sys_bus_decoder; region 7 is left unmapped.
module tb_sys_bus_decoder;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned N  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic          wen, ren;
  logic [DW-1:0] rdata;
  logic          err, ack;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_sel;
  logic [N-1:0]  s_wen, s_ren;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]  s_err, s_ack;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sys_bus_decoder #(
    .SYS_DW (DW),
    .SYS_AW (AW),
    .SYS_SW (SW),
    .SN     (N),
    .DEC_LSB(20),
    .REG_EN (8'h7F),
    .TMO    (16)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rstn),
    .sys_addr_i (addr),
    .sys_wdata_i(wdata),
    .sys_sel_i  (sel),
    .sys_wen_i  (wen),
    .sys_ren_i  (ren),
    .sys_rdata_o(rdata),
    .sys_err_o  (err),
    .sys_ack_o  (ack),
    .sub_addr_o (s_addr),
    .sub_wdata_o(s_wdata),
    .sub_sel_o  (s_sel),
    .sub_wen_o  (s_wen),
    .sub_ren_o  (s_ren),
    .sub_rdata_i(s_rdata),
    .sub_err_i  (s_err),
    .sub_ack_i  (s_ack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; addr = '0; wdata = '0; sel = '0; wen = 1'b0; ren = 1'b0;
    s_rdata = '0; s_err = '0; s_ack = '0;
    tick(); tick();
    check_eq("rst_ack",   64'(ack), 64'd0);
    check_eq("rst_err",   64'(err), 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    check_eq("rst_wen",   64'(s_wen), 64'd0);
    check_eq("rst_ren",   64'(s_ren), 64'd0);
    check_eq("rst_addr",  64'(s_addr), 64'd0);
    rstn = 1'b1;
    tick();

    // Write region 3, combinational ack in the strobe cycle.
    addr = 32'h0030_0008; wdata = 64'hDEAD_BEEF_0123_4567; sel = 8'hFF; wen = 1'b1;
    tick();
    check_eq("w_wen",   64'(s_wen), 64'h08);
    check_eq("w_ren",   64'(s_ren), 64'h00);
    check_eq("w_addr",  64'(s_addr), 64'h0030_0008);
    check_eq("w_wdata", s_wdata, 64'hDEAD_BEEF_0123_4567);
    check_eq("w_sel",   64'(s_sel), 64'hFF);
    check_eq("w_ack_t1", 64'(ack), 64'd0);
    wen = 1'b0; s_ack = 8'h08; s_err = 8'h00;
    tick();
    check_eq("w_ack",   64'(ack), 64'd1);
    check_eq("w_err",   64'(err), 64'd0);
    check_eq("w_rdata", rdata, 64'd0);
    check_eq("w_wen_off", 64'(s_wen), 64'h00);
    s_ack = '0;
    tick();
    check_eq("w_ack_pulse", 64'(ack), 64'd0);

    // Read region 5, ack 4 cycles after the strobe with error.
    addr = 32'h0050_0000; ren = 1'b1;
    tick();
    check_eq("r5_ren", 64'(s_ren), 64'h20);
    ren = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_eq("r5_wait", 64'(ack), 64'd0);
    end
    s_ack = 8'h20; s_err = 8'h20; s_rdata[5*DW +: DW] = 64'h1122_3344_5566_7788;
    tick();
    check_eq("r5_ack",   64'(ack), 64'd1);
    check_eq("r5_err",   64'(err), 64'd1);
    check_eq("r5_rdata", rdata, 64'h1122_3344_5566_7788);
    s_ack = '0; s_err = '0;
    tick();
    check_eq("r5_hold", rdata, 64'h1122_3344_5566_7788);

    // Unmapped region 7.
    addr = 32'h0070_0000; ren = 1'b1;
    tick();
    check_eq("u_ren", 64'(s_ren), 64'h00);
    check_eq("u_wen", 64'(s_wen), 64'h00);
    check_eq("u_ack_t1", 64'(ack), 64'd0);
    ren = 1'b0;
    tick();
    check_eq("u_ack",   64'(ack), 64'd1);
    check_eq("u_err",   64'(err), 64'd1);
    check_eq("u_rdata", rdata, 64'd0);

    // Timeout on region 2.
    tick();
    addr = 32'h0020_0000; ren = 1'b1;
    tick();
    check_eq("t_ren", 64'(s_ren), 64'h04);
    ren = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      check_eq("t_wait", 64'(ack), 64'd0);
    end
    tick();
    check_eq("t_ack", 64'(ack), 64'd1);
    check_eq("t_err", 64'(err), 64'd1);
    tick(); tick();
    check_eq("t_ack_pulse", 64'(ack), 64'd0);
    tick();
    s_ack = 8'h04;
    tick();
    check_eq("t_late_ack", 64'(ack), 64'd0);
    check_eq("t_late_ren", 64'(s_ren), 64'h00);
    s_ack = '0;
    tick();

    // Region 4 selected, foreign ack and a dropped upstream strobe.
    addr = 32'h0040_0010; ren = 1'b1;
    tick();
    check_eq("f_ren", 64'(s_ren), 64'h10);
    s_ack = 8'h02; s_rdata[1*DW +: DW] = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    check_eq("f_foreign", 64'(ack), 64'd0);
    check_eq("f_drop_ren", 64'(s_ren), 64'h00);
    s_ack = '0; ren = 1'b0;
    s_ack = 8'h10; s_rdata[4*DW +: DW] = 64'h4444_0000_AAAA_5555;
    tick();
    check_eq("f_ack",   64'(ack), 64'd1);
    check_eq("f_err",   64'(err), 64'd0);
    check_eq("f_rdata", rdata, 64'h4444_0000_AAAA_5555);
    s_ack = '0;
    tick();
    check_eq("f_no_extra_ack", 64'(ack), 64'd0);
    check_eq("f_no_extra_ren", 64'(s_ren), 64'h00);
    tick();
    check_eq("f_no_extra_ack2", 64'(ack), 64'd0);

    // Back-to-back: new request in the ack cycle; both strobes high -> write.
    addr = 32'h0000_0100; wen = 1'b1; ren = 1'b1;
    tick();
    check_eq("b_wen", 64'(s_wen), 64'h01);
    check_eq("b_ren", 64'(s_ren), 64'h00);
    wen = 1'b0; ren = 1'b0; s_ack = 8'h01;
    tick();
    check_eq("b_ack1", 64'(ack), 64'd1);
    s_ack = '0; addr = 32'h0010_0000; ren = 1'b1;
    s_rdata[1*DW +: DW] = 64'h0101_0202_0303_0404;
    tick();
    check_eq("b_ren2", 64'(s_ren), 64'h02);
    ren = 1'b0; s_ack = 8'h02;
    tick();
    check_eq("b_ack2",  64'(ack), 64'd1);
    check_eq("b_rdata", rdata, 64'h0101_0202_0303_0404);
    s_ack = '0;
    tick();

    // Reset while busy on region 6.
    addr = 32'h0060_0000; ren = 1'b1;
    tick();
    check_eq("x_ren", 64'(s_ren), 64'h40);
    ren = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    check_eq("x_ack",   64'(ack), 64'd0);
    check_eq("x_rdata", rdata, 64'd0);
    check_eq("x_addr",  64'(s_addr), 64'd0);
    rstn = 1'b1; s_ack = 8'h40;
    tick();
    check_eq("x_late_ack", 64'(ack), 64'd0);
    s_ack = '0;
    tick();
    addr = 32'h0030_0000; wdata = 64'h5; wen = 1'b1;
    tick();
    check_eq("x_wen", 64'(s_wen), 64'h08);
    wen = 1'b0; s_ack = 8'h08;
    tick();
    check_eq("x_ack_ok", 64'(ack), 64'd1);
    check_eq("x_err_ok", 64'(err), 64'd0);
    s_ack = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
